rr_arb_idx_gen: RTL and testbench
=================================

Name: rr_arb_idx_gen

Overview:
- 16-requester round-robin arbiter that emits an encoded grant (enable plus 4-bit index), not a one-hot vector.
- Sits directly upstream of the 4-to-16 one-hot decoder: gnt_en drives the decoder enable, gnt_idx drives its select input.
- Grants are held until the requester acknowledges, drops its request, or exceeds a maximum hold time.

Parameters:
- N, 16: number of requesters. Must equal 2**IDX_W.
- IDX_W, 4: grant index width.
- MAX_HOLD, 8: maximum cycles a single grant may be held before forced release. Minimum 2.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i is requester i.
- ack  input  1  granted requester finished; releases the current grant.
- gnt_en  output  1  grant valid; drives the decoder enable.
- gnt_idx  output  IDX_W  index of the granted requester; drives the decoder select.
- timeout  output  1  one-cycle pulse when a grant is force-released by the hold limit.

Behaviour:
- Reset (synchronous, on rst=1 at a rising edge):
  - gnt_en=0, gnt_idx=0, timeout=0, state=IDLE, ptr=0, hold_cnt=0.
  - Reset asserted mid-grant drops gnt_en at that same edge. ack is ignored while rst=1.
- All outputs are registered; there is no combinational path from req or ack to any output.
- Selection rule (pick):
  - Scan req starting at index ptr, ascending, wrapping from N-1 to 0.
  - The first set bit wins. No set bit means no winner.
- State IDLE:
  - gnt_en=0.
  - If req!=0, pick a winner, register gnt_idx=winner, gnt_en=1, hold_cnt=0, and go to GRANT.
  - Latency: req sampled at edge t gives gnt_en=1 after edge t, visible at t+1.
- State GRANT:
  - gnt_en=1 and gnt_idx stable.
  - Release conditions, checked each edge, any one suffices:
    - (a) ack=1;
    - (b) req[gnt_idx]=0;
    - (c) hold_cnt==MAX_HOLD-1.
  - On release:
    - ptr <= gnt_idx+1, modulo N (15 wraps to 0).
    - Immediately re-pick using the new pointer value against the current req with bit gnt_idx masked.
    - If a winner exists: stay in GRANT with the new gnt_idx and hold_cnt=0. This is back-to-back with no gnt_en gap.
    - If no other requester exists but req[gnt_idx] is still 1: re-grant the same index (it is the sole requester), hold_cnt=0.
    - Otherwise: go to IDLE with gnt_en=0.
  - Without release: hold_cnt increments by 1.
  - hold_cnt is $clog2(MAX_HOLD) bits wide and never wraps, because release (c) fires first.
- timeout:
  - Set to 1 for exactly one cycle, the cycle after a release caused by (c) while (a) and (b) are both false.
  - If (a) or (b) coincides with (c), the release is normal and timeout stays 0.
- Simultaneous events: ack together with a req change in the same cycle uses the req value sampled at that edge for the re-pick.
- ptr updates only on release, never in IDLE. Fairness guarantee: any continuously asserting requester is granted within N-1 grants.
- ack while in IDLE is ignored.

Decomposition:
- Shared package rr_arb_pkg holds:
  - localparams N=16, IDX_W=4;
  - the state enum {IDLE, GRANT};
  - a function inc_wrap(idx) returning (idx+1) mod N.
- One combinational sub-module, rr_pick:
  - inputs: req[N], ptr[IDX_W], mask_en, mask_idx;
  - outputs: found, idx.
  - Implemented as a rotate, find-first, un-rotate.
  - Instantiated once and shared by the IDLE and GRANT re-pick paths.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=16'hFFFF -> gnt_en=0, gnt_idx=0, timeout=0 throughout. After release of rst, the first grant is idx 0 one cycle later.
- Rotation: req=16'h8421 held, ack pulsed on every grant -> gnt_idx sequence 0,5,10,15,0,..., gnt_en continuously 1 with no gaps.
- Wrap: ptr at 15 after granting 14, req=16'h4001 -> next grant is idx 0, then 14. Confirms modulo-16 pointer wrap.
- Sole requester: req=16'h0040 only, ack each grant -> re-granted idx 6 back-to-back. Drop req -> gnt_en=0 one cycle later and state returns to IDLE.
- Timeout: req=16'h0003, no ack, MAX_HOLD=8 -> idx 0 held 8 cycles, timeout pulses 1 cycle, then idx 1 granted. Again 8 cycles later, timeout pulses and idx 0 is granted.
- Mid-grant reset and coincident events:
  - rst=1 during a GRANT on idx 9 -> gnt_en=0 at the next edge and ptr returns to 0.
  - ack coinciding with hold_cnt=7 -> release with timeout=0.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin encoded-grant arbiter.
//   N        : number of requesters (must equal 2**IDX_W)
//   IDX_W    : width of an encoded requester index
//   state_t  : arbiter state, IDLE (no grant) or GRANT (grant held)
//   inc_wrap : next index after idx, modulo N
package rr_arb_pkg;

  localparam int N     = 16;
  localparam int IDX_W = 4;

  typedef enum logic {IDLE, GRANT} state_t;

  // N == 2**IDX_W, so plain truncation of idx+1 is the modulo-N wrap.
  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] idx);
    return IDX_W'(idx + 1'b1);
  endfunction

endpackage

// File: rtl/rr_arb_idx_gen_pick.sv
// rr_pick: combinational round-robin selector.
//   req      : request vector
//   ptr      : highest-priority index; the scan runs ptr, ptr+1, ... wrapping
//   mask_en  : when set, ignore req[mask_idx] (the grant being released)
//   mask_idx : index to ignore
//   found    : some unmasked request is set
//   idx      : first unmasked request at or after ptr
// Done as rotate-by-ptr, find-first-set from bit 0, then add ptr back.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             mask_en,
  input  logic [IDX_W-1:0] mask_idx,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0]     req_m;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;

  always_comb begin
    req_m = req;
    if (mask_en) req_m[mask_idx] = 1'b0;
  end

  // rot[i] is requester (ptr+i) mod N; index truncation does the wrap.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++)
      rot[i] = req_m[IDX_W'(i + int'(ptr))];
  end

  // Descending loop so the lowest set bit is the last assignment to stick.
  always_comb begin
    found = |rot;
    off   = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) off = IDX_W'(i);
  end

  assign idx = IDX_W'(ptr + off);

endmodule

// File: rtl/rr_arb_idx_gen.sv
// rr_arb_idx_gen: 16-requester round-robin arbiter with encoded grant output,
// meant to feed a 4-to-16 one-hot decoder (gnt_en -> enable, gnt_idx -> select).
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   req      : request vector, bit i = requester i
//   ack      : current grantee is done; releases the grant
//   gnt_en   : grant valid (registered)
//   gnt_idx  : granted requester index (registered)
//   timeout  : one-cycle pulse after a grant is force-released by MAX_HOLD
// A grant is released on ack, on the grantee dropping its request, or after
// MAX_HOLD cycles. On release the next requester is picked in the same edge,
// so grants run back-to-back with no gnt_en bubble.
module rr_arb_idx_gen
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8   // minimum 2
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             ack,
  output logic             gnt_en,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             timeout
);

  localparam int            HW        = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [HW-1:0]    hold_cnt;

  logic             in_grant;
  logic [IDX_W-1:0] pick_ptr;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             rel_ack, rel_drop, rel_hold, rel;

  assign in_grant = (state == GRANT);

  // One picker serves both paths: from IDLE it scans from ptr; in GRANT it
  // scans from the pointer value a release would install, with the current
  // grantee masked so another requester gets the first chance.
  assign pick_ptr = in_grant ? inc_wrap(gnt_idx) : ptr;

  rr_pick u_pick (
    .req      (req),
    .ptr      (pick_ptr),
    .mask_en  (in_grant),
    .mask_idx (gnt_idx),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  assign rel_ack  = ack;
  assign rel_drop = ~req[gnt_idx];
  assign rel_hold = (hold_cnt == HOLD_LAST);
  assign rel      = rel_ack | rel_drop | rel_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt_en   <= 1'b0;
      gnt_idx  <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= GRANT;
            gnt_en   <= 1'b1;
            gnt_idx  <= pick_idx;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            ptr     <= inc_wrap(gnt_idx);
            // Only a pure hold-limit release counts as a timeout.
            timeout <= rel_hold & ~rel_ack & ~rel_drop;
            if (pick_found) begin
              gnt_idx  <= pick_idx;
              hold_cnt <= '0;
            end else if (req[gnt_idx]) begin
              // Sole requester: re-grant the same index with a fresh hold.
              hold_cnt <= '0;
            end else begin
              state  <= IDLE;
              gnt_en <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb_idx_gen.sv
// Self-checking bench for rr_arb_idx_gen: directed scenarios followed by
// random traffic, every cycle compared against a behavioural model of the
// arbitration rules, plus directed constant checks at key points.
module tb_rr_arb_idx_gen;

  localparam int NREQ = 16;
  localparam int MAXH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        ack;
  logic        gnt_en;
  logic [3:0]  gnt_idx;
  logic        timeout;

  int errs   = 0;
  int checks = 0;

  // reference model state
  int m_en, m_idx, m_ptr, m_hold, m_to;

  rr_arb_idx_gen #(.MAX_HOLD(MAXH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .gnt_en  (gnt_en),
    .gnt_idx (gnt_idx),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // First set request at or after p (wrapping), skipping index skip.
  function automatic int scan(input logic [15:0] r, input int p, input int skip);
    int j;
    for (int k = 0; k < NREQ; k++) begin
      j = (p + k) % NREQ;
      if (j != skip && r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [15:0] r, input logic a, input logic rs);
    int  w;
    bit  ra, rb, rc;
    if (rs) begin
      m_en = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 0;
      return;
    end
    m_to = 0;
    if (m_en == 0) begin
      w = scan(r, m_ptr, -1);
      if (w >= 0) begin m_en = 1; m_idx = w; m_hold = 0; end
    end else begin
      ra = a;
      rb = !r[m_idx];
      rc = (m_hold == MAXH - 1);
      if (ra || rb || rc) begin
        m_ptr = (m_idx + 1) % NREQ;
        m_to  = (rc && !ra && !rb) ? 1 : 0;
        w = scan(r, m_ptr, m_idx);
        if (w >= 0) begin m_idx = w; m_hold = 0; end
        else if (r[m_idx]) m_hold = 0;
        else m_en = 0;
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
      else begin
        errs++;
        $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
      end
  endtask

  // Drive one cycle, advance the model on the edge, compare 1 time unit later.
  task automatic step(input logic [15:0] r, input logic a, input logic rs);
    req = r; ack = a; rst = rs;
    @(posedge clk);
    model_edge(r, a, rs);
    #1;
    chk("gnt_en",  int'(gnt_en),  m_en);
    chk("gnt_idx", int'(gnt_idx), m_idx);
    chk("timeout", int'(timeout), m_to);
  endtask

  int rot_exp[8] = '{5, 10, 15, 0, 5, 10, 15, 0};

  initial begin
    req = '0; ack = 1'b0; rst = 1'b1;

    // reset with all requesting
    step(16'hFFFF, 1'b0, 1'b1);
    step(16'hFFFF, 1'b0, 1'b1);
    chk("rst_en", int'(gnt_en), 0);
    chk("rst_idx", int'(gnt_idx), 0);
    step(16'hFFFF, 1'b0, 1'b0);
    chk("first_en", int'(gnt_en), 1);
    chk("first_idx", int'(gnt_idx), 0);

    // rotation with ack on every grant
    for (int i = 0; i < 8; i++) begin
      step(16'h8421, 1'b1, 1'b0);
      chk("rot_idx", int'(gnt_idx), rot_exp[i]);
      chk("rot_en", int'(gnt_en), 1);
    end

    // pointer wrap 14 -> 15 -> 0
    step(16'h4001, 1'b1, 1'b0);
    chk("wrap_a", int'(gnt_idx), 14);
    step(16'h4001, 1'b1, 1'b0);
    chk("wrap_b", int'(gnt_idx), 0);
    step(16'h4001, 1'b1, 1'b0);
    chk("wrap_c", int'(gnt_idx), 14);

    // sole requester re-granted back-to-back
    for (int i = 0; i < 4; i++) begin
      step(16'h0040, 1'b1, 1'b0);
      chk("sole_idx", int'(gnt_idx), 6);
      chk("sole_en", int'(gnt_en), 1);
    end
    step(16'h0000, 1'b0, 1'b0);
    chk("sole_drop", int'(gnt_en), 0);
    step(16'h0000, 1'b1, 1'b0);
    chk("idle_ack", int'(gnt_en), 0);

    // hold-limit timeout, twice
    step(16'h0003, 1'b0, 1'b0);
    chk("to_start", int'(gnt_idx), 0);
    for (int i = 0; i < MAXH - 1; i++) begin
      step(16'h0003, 1'b0, 1'b0);
      chk("to_hold0", int'(gnt_idx), 0);
      chk("to_quiet0", int'(timeout), 0);
    end
    step(16'h0003, 1'b0, 1'b0);
    chk("to_pulse1", int'(timeout), 1);
    chk("to_next1", int'(gnt_idx), 1);
    for (int i = 0; i < MAXH - 1; i++) begin
      step(16'h0003, 1'b0, 1'b0);
      chk("to_hold1", int'(gnt_idx), 1);
      chk("to_quiet1", int'(timeout), 0);
    end
    step(16'h0003, 1'b0, 1'b0);
    chk("to_pulse2", int'(timeout), 1);
    chk("to_next2", int'(gnt_idx), 0);

    // ack coinciding with the hold limit: normal release
    for (int i = 0; i < MAXH - 1; i++) step(16'h0003, 1'b0, 1'b0);
    step(16'h0003, 1'b1, 1'b0);
    chk("ack_lim_to", int'(timeout), 0);
    chk("ack_lim_idx", int'(gnt_idx), 1);

    // reset in the middle of a grant on 9
    step(16'h0200, 1'b1, 1'b0);
    chk("g9_idx", int'(gnt_idx), 9);
    step(16'h0200, 1'b0, 1'b0);
    step(16'h0200, 1'b1, 1'b1);
    chk("midrst_en", int'(gnt_en), 0);
    step(16'hFFFF, 1'b0, 1'b0);
    chk("midrst_ptr", int'(gnt_idx), 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] r;
      logic        a, s;
      r = 16'($urandom) & 16'($urandom);
      a = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 49) == 0);
      step(r, a, s);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
